// File: rtl/result_collector.sv
// result_collector
//
// Downstream stage of the calculator. Watches the calculator's level-style
// `valid` output and treats each rising edge as a packet completion. Every
// completion captures {id, res} into a small FIFO that drains through a
// valid/ready port. Completions that find the FIFO full (with no pop in the
// same cycle) are dropped and counted. The block also checks that completion
// ids follow the generator's sequence.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, >= 2)
//   DROP_W  - width of the saturating drop counter
//
// Ports:
//   clk        - clock
//   rst        - synchronous, active-high reset
//   res_in     - calculator result (32 bits)
//   id_in      - calculator packet id (13 bits)
//   valid_in   - calculator valid level
//   out_valid  - head entry available
//   out_ready  - consumer accepts head entry
//   out_id     - id of head entry (0 when out_valid is low)
//   out_res    - result of head entry (0 when out_valid is low)
//   count      - current FIFO occupancy
//   overflow   - sticky: at least one completion was dropped
//   drop_cnt   - number of dropped completions, saturating
//   seq_err    - sticky: a completion id broke the expected sequence
module result_collector #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              res_in,
  input  logic [12:0]              id_in,
  input  logic                     valid_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [12:0]              out_id,
  output logic [31:0]              out_res,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     seq_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 13 + 32;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // The generator never emits this id, so the id after SKIP_FROM is SKIP_TO.
  localparam logic [12:0] SKIP_FROM = 13'h1F82;
  localparam logic [12:0] SKIP_TO   = 13'h1F84;

  // Entry storage; intentionally not reset, occupancy tracking makes it safe.
  logic [EW-1:0] mem [DEPTH];

  logic              valid_q_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_cnt_reg;
  logic              seq_err_reg;
  logic              seen_reg;
  logic [12:0]       last_id_reg;

  logic        done;
  logic        pop;
  logic        push;
  logic        drop;
  logic        full;
  logic        id_mismatch;
  logic [12:0] expected_id;
  logic [EW-1:0] head_entry;

  // A completion is the rising edge of the calculator's valid level.
  // valid_q resets to 1 so the valid level present right after reset is
  // not mistaken for a completion.
  assign done = valid_in & ~valid_q_reg;
  assign full = (count_reg == FULL_COUNT);
  assign pop  = out_valid & out_ready;
  // A full FIFO can still accept a push when the head leaves this cycle.
  assign push = done & (~full | pop);
  assign drop = done & full & ~pop;

  assign expected_id = (last_id_reg == SKIP_FROM) ? SKIP_TO : (last_id_reg + 13'd1);
  assign id_mismatch = seen_reg & (id_in != expected_id);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q_reg  <= 1'b1;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
      seq_err_reg  <= 1'b0;
      seen_reg     <= 1'b0;
      last_id_reg  <= '0;
    end else begin
      valid_q_reg <= valid_in;
      count_reg   <= count_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != {DROP_W{1'b1}}) begin
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
      end

      // Sequence tracking includes dropped completions: the generator's id
      // stream is what is being checked, not what was stored.
      if (done) begin
        if (id_mismatch) begin
          seq_err_reg <= 1'b1;
        end
        last_id_reg <= id_in;
        seen_reg    <= 1'b1;
      end
    end
  end

  // Storage write has no reset so it maps cleanly onto memory primitives.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= {id_in, res_in};
    end
  end

  // The head must be visible the cycle right after its push, so the read is
  // asynchronous from the read pointer rather than through a read register.
  assign head_entry = mem[rd_ptr_reg];

  assign out_valid = (count_reg != '0);
  assign out_id    = out_valid ? head_entry[EW-1:32] : 13'd0;
  assign out_res   = out_valid ? head_entry[31:0]    : 32'd0;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign seq_err   = seq_err_reg;

endmodule

// File: tb/tb_result_collector.sv
// Testbench for result_collector: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_result_collector;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic        clk;
  logic        rst;
  logic [31:0] res_in;
  logic [12:0] id_in;
  logic        valid_in;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_id;
  logic [31:0] out_res;
  logic [2:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        seq_err;

  result_collector #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_in    (res_in),
    .id_in     (id_in),
    .valid_in  (valid_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_res   (out_res),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [44:0] m_q[$];
  logic        m_over;
  logic [7:0]  m_drop;
  logic        m_seq;
  logic        m_seen;
  logic [12:0] m_last;
  logic        m_vq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [44:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 45'd0;
    chk("count", 64'(count), 64'(m_q.size()));
    chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    chk("out_id", 64'(out_id), 64'(head[44:32]));
    chk("out_res", 64'(out_res), 64'(head[31:0]));
    chk("overflow", 64'(overflow), 64'(m_over));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("seq_err", 64'(seq_err), 64'(m_seq));
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, check.
  task automatic step(input logic v, input logic [12:0] id, input logic [31:0] r,
                      input logic rdy, input logic rs);
    logic        is_done;
    logic        is_pop;
    logic [12:0] exp_id;
    valid_in  = v;
    id_in     = id;
    res_in    = r;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_over = 1'b0;
      m_drop = 8'd0;
      m_seq  = 1'b0;
      m_seen = 1'b0;
      m_last = 13'd0;
      m_vq   = 1'b1;
    end else begin
      is_done = v && !m_vq;
      m_vq    = v;
      is_pop  = rdy && (m_q.size() != 0);
      if (is_pop) void'(m_q.pop_front());
      if (is_done) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({id, r});
        end else begin
          m_over = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
        exp_id = (m_last == 13'h1F82) ? 13'h1F84 : m_last + 13'd1;
        if (m_seen && id != exp_id) m_seq = 1'b1;
        m_last = id;
        m_seen = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b1, 13'd0, 32'd0, 1'b0, 1'b1);
  endtask

  // Valid low for one cycle then high: one completion on the high cycle.
  task automatic complete(input logic [12:0] id, input logic [31:0] r, input logic rdy);
    step(1'b0, 13'd0, 32'd0, rdy, 1'b0);
    step(1'b1, id, r, rdy, 1'b0);
  endtask

  initial begin
    logic [12:0] gen_id;
    logic        prev_v;
    logic        v;
    logic        rs;
    logic        rdy;
    logic [12:0] id;

    valid_in = 1'b1; id_in = '0; res_in = '0; out_ready = 1'b0; rst = 1'b1;
    m_vq = 1'b1; m_over = 0; m_drop = 0; m_seq = 0; m_seen = 0; m_last = 0;

    // Reset state
    do_reset();
    do_reset();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    step(1'b1, 13'd0, 32'd0, 1'b0, 1'b0);
    chk("no_done_after_reset", 64'(out_valid), 64'd0);

    // Single packet
    step(1'b0, 13'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 13'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 13'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 13'h0005, 32'h0000_002A, 1'b1, 1'b0);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_id", 64'(out_id), 64'h5);
    chk("single_res", 64'(out_res), 64'h2A);
    step(1'b1, 13'h0005, 32'h0000_002A, 1'b1, 1'b0);
    chk("single_count_back", 64'(count), 64'd0);
    chk("single_seq", 64'(seq_err), 64'd0);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 5; i++) complete(13'(i), 32'(i * 100), 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drop", 64'(drop_cnt), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_id", 64'(out_id), 64'(i));
      step(1'b1, 13'd0, 32'd0, 1'b1, 1'b0);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Full with simultaneous push and pop
    for (int i = 6; i <= 9; i++) complete(13'(i), 32'(i * 7), 1'b0);
    step(1'b0, 13'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 13'd10, 32'hABCD_0010, 1'b1, 1'b0);
    chk("pushpop_count", 64'(count), 64'd4);
    chk("pushpop_drop", 64'(drop_cnt), 64'd1);
    for (int i = 7; i <= 10; i++) begin
      chk("pushpop_order", 64'(out_id), 64'(i));
      step(1'b1, 13'd0, 32'd0, 1'b1, 1'b0);
    end

    // Id skip
    do_reset();
    complete(13'h1F82, 32'd1, 1'b1);
    complete(13'h1F84, 32'd2, 1'b1);
    chk("skip_ok", 64'(seq_err), 64'd0);
    do_reset();
    complete(13'h1F82, 32'd1, 1'b1);
    complete(13'h1F83, 32'd2, 1'b1);
    chk("skip_bad", 64'(seq_err), 64'd1);

    // Wrap
    do_reset();
    complete(13'h1FFF, 32'd1, 1'b1);
    complete(13'h0000, 32'd2, 1'b1);
    chk("wrap_ok", 64'(seq_err), 64'd0);
    do_reset();
    complete(13'h0007, 32'd1, 1'b1);
    complete(13'h0009, 32'd2, 1'b1);
    chk("gap_bad", 64'(seq_err), 64'd1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      complete(13'(20 + i), 32'(i), 1'b0);
      chk("ptr_wrap_id", 64'(out_id), 64'(20 + i));
      step(1'b1, 13'd0, 32'd0, 1'b1, 1'b0);
    end

    // Reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) complete(13'(i), 32'(i), 1'b0);
    step(1'b1, 13'd0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 13'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 13'd0, 32'd0, 1'b0, 1'b0);
    chk("mid_count", 64'(count), 64'd2);
    chk("mid_overflow", 64'(overflow), 64'd1);
    step(1'b1, 13'd77, 32'd77, 1'b1, 1'b1);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_flags", 64'({overflow, seq_err, drop_cnt}), 64'd0);
    complete(13'd100, 32'd5, 1'b0);
    chk("mid_first_id", 64'(out_id), 64'd100);
    chk("mid_first_seq", 64'(seq_err), 64'd0);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 262; i++) complete(13'(i), 32'(i), 1'b0);
    chk("drop_sat", 64'(drop_cnt), 64'hFF);

    // Randomized traffic
    do_reset();
    gen_id = 13'h1F70;
    prev_v = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      v   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) == 0);
      if (n > 700) rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 199) == 0);
      id  = ($urandom_range(0, 19) == 0) ? 13'($urandom) : gen_id;
      step(v, id, $urandom, rdy, rs);
      if (rs) prev_v = 1'b1;
      else begin
        if (v && !prev_v) gen_id = (gen_id == 13'h1F82) ? 13'h1F84 : gen_id + 13'd1;
        prev_v = v;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the calculator. Samples the calculator's `res`, `id` and `valid` outputs and detects each packet completion. On every completion it pushes one `{id, res}` entry into a small FIFO. Entries drain through a valid/ready output port, and the block flags overflow drops and breaks in the generator's id sequence.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, at least 2.
- `DROP_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `res_in`, input, 32: calculator `res`.
- `id_in`, input, 13: calculator `id`.
- `valid_in`, input, 1: calculator `valid` (level: high while the calculator's remaining-arg count is 0).
- `out_valid`, output, 1: head entry available.
- `out_ready`, input, 1: consumer accepts the head entry.
- `out_id`, output, 13: id of the head entry.
- `out_res`, output, 32: result of the head entry.
- `count`, output, $clog2(DEPTH)+1: current occupancy.
- `overflow`, output, 1: sticky; a completion was dropped.
- `drop_cnt`, output, DROP_W: dropped completions, saturating.
- `seq_err`, output, 1: sticky; a completion id broke the expected sequence.

## Operation
- `valid_q` is a register holding last cycle's `valid_in`. Its reset value is 1, so the high `valid_in` after reset is not a completion.
- `done = valid_in & !valid_q`. A packet whose header has length 0 produces no rising edge, so it produces no entry. This is intended.
- On `done`, the entry is `{id_in, res_in}`, sampled in the same cycle. The calculator updates `res` and the count on the same edge, so both values are final.
- `pop = out_valid & out_ready`.
- `push = done & (count < DEPTH | pop)`: a full FIFO accepts a push in the same cycle as a pop.
- If `done` occurs while the FIFO is full and there is no pop:
  - the entry is discarded;
  - `overflow` is set to 1;
  - `drop_cnt` increments, saturating at all-ones.
- `count` changes as follows: +1 for push only, −1 for pop only, unchanged for both or neither.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- Storage is not reset.
- `out_valid = (count != 0)`.
- `out_id` and `out_res` show the entry at the read pointer when `out_valid` is 1. They are forced to 0 when `out_valid` is 0.
- Sequence check:
  - It runs on every `done`, including dropped completions.
  - The first `done` after reset loads `last_id` and never raises `seq_err`.
  - The expected next id is `last_id + 1` (13-bit wrap, 0x1FFF goes to 0x0000), except that `last_id == 0x1F82` expects 0x1F84. This matches the generator skipping 0x1F83.
  - On a mismatch, `seq_err` is set. `last_id` always updates to `id_in`.
- `overflow`, `seq_err` and `drop_cnt` are cleared only by `rst`.

## Timing
- Reset values: `out_valid` 0, `out_id` 0, `out_res` 0, `count` 0, `overflow` 0, `drop_cnt` 0, `seq_err` 0, `valid_q` 1, pointers 0, the "first done seen" flag 0.
- `rst` wins over all activity in the same cycle. A completion or pop in the reset cycle is lost.
- Latency: `done` in cycle N gives `out_valid` = 1 and the entry at the head (if the FIFO was empty) in cycle N+1.
- Pop in cycle N: the next entry, or `out_valid` = 0, appears in cycle N+1.
- Handshake rules:
  - `out_id` and `out_res` hold stable while `out_valid & !out_ready`.
  - `out_valid` never drops without a pop, except on reset.
- Sticky flags assert in cycle N+1 after the offending `done` in cycle N.
- `count` is registered and reflects pushes and pops from the prior cycle.

## Test plan
- **Single packet.** After reset, `valid_in` 1→0 for 3 cycles then 1, with `id_in` 0x0005 and `res_in` 0x0000_002A at the rising cycle, `out_ready` 1 → one cycle of `out_valid` with `out_id` 0x0005 and `out_res` 0x2A; `count` returns to 0; `seq_err` stays 0.
- **Fill and overflow.** DEPTH=4, `out_ready` 0, 5 completions with ids 1–5 → `count` is 4, entries 1–4 are retained, `overflow` is 1, `drop_cnt` is 1. Raising `out_ready` then drains ids 1,2,3,4 in order.
- **Full with simultaneous push and pop.** FIFO full, with `done` and `out_ready` both high in one cycle → `count` stays 4, no drop, and the new entry appears last.
- **Id skip.** Completions with ids 0x1F82 then 0x1F84 → `seq_err` stays 0. Completions with ids 0x1F82 then 0x1F83 → `seq_err` is 1 from the next cycle.
- **Wrap.** Ids 0x1FFF then 0x0000 → no `seq_err`. Ids 0x0007 then 0x0009 → `seq_err` is 1. Read and write pointers wrap correctly after 6 push/pop pairs.
- **Reset mid-operation.** Assert `rst` with 2 entries held and `overflow` set → the next cycle shows `count` 0, `out_valid` 0, all flags 0. The next `valid_in` rise after reset is treated as the first completion and raises no `seq_err`.
